// File: rtl/dmem_port_arbiter_if.sv
// Bundle between the fetch unit, data cache, memory port and arbiter.
// The arbiter sits on the slave side; requesters and memory form the master side.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_start;
  logic [ADDR_W-1:0] if_addr;
  logic              if_stop;
  logic [31:0]       if_rdata;
  logic              dc_start;
  logic              dc_second;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [31:0]       dc_wdata;
  logic              dc_stop;
  logic [31:0]       dc_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              busy;

  modport slave (
    input  if_start, if_addr,
    input  dc_start, dc_second, dc_we,
    input  dc_addr, dc_wdata,
    input  mem_rdata,
    output if_stop, if_rdata,
    output dc_stop, dc_rdata,
    output mem_en, mem_we,
    output mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output if_start, if_addr,
    output dc_start, dc_second, dc_we,
    output dc_addr, dc_wdata,
    output mem_rdata,
    input  if_stop, if_rdata,
    input  dc_stop, dc_rdata,
    input  mem_en, mem_we,
    input  mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one fixed-latency data-memory port between fetch and the data
// cache, keeping the port locked across a cache writeback/refill pair.
module dmem_port_arbiter #(
  parameter int MEM_LATENCY = 3,
  parameter int ADDR_W      = 32
) (
  input logic               clk,
  input logic               rst_b,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_DC   = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t            state;
  logic              owner;
  logic              rr_ptr;
  logic              lock;
  logic              we_q;
  logic              second_q;
  logic [3:0]        cnt;
  logic [31:0]       if_rdata_q;
  logic [31:0]       dc_rdata_q;
  logic              req;
  logic              tie;
  logic              pick_dc;
  logic [ADDR_W-1:0] grant_addr;
  logic              resp_rd;

  always_comb begin
    req  = bus.if_start | bus.dc_start;
    tie  = bus.if_start & bus.dc_start & ~lock;
    if (lock && bus.dc_start)
      pick_dc = 1'b1;
    else if (tie)
      pick_dc = rr_ptr;
    else
      pick_dc = bus.dc_start;
    grant_addr = pick_dc ? bus.dc_addr : bus.if_addr;
  end

  // Read data is forwarded in the stop cycle, then held in the register.
  assign resp_rd = (state == RESP) && !we_q;
  assign bus.if_rdata =
    (resp_rd && owner == OWN_IF) ? bus.mem_rdata : if_rdata_q;
  assign bus.dc_rdata =
    (resp_rd && owner == OWN_DC) ? bus.mem_rdata : dc_rdata_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      rr_ptr        <= OWN_DC;
      lock          <= 1'b0;
      we_q          <= 1'b0;
      second_q      <= 1'b0;
      cnt           <= '0;
      if_rdata_q    <= '0;
      dc_rdata_q    <= '0;
      bus.if_stop   <= 1'b0;
      bus.dc_stop   <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (lock && !bus.dc_start) lock <= 1'b0;
          if (req) begin
            if (tie) rr_ptr <= ~rr_ptr;
            owner         <= pick_dc;
            we_q          <= pick_dc & bus.dc_we;
            second_q      <= pick_dc & bus.dc_second;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= pick_dc & bus.dc_we;
            bus.mem_addr  <= grant_addr;
            bus.mem_wdata <= pick_dc ? bus.dc_wdata : '0;
            bus.busy      <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          cnt        <= CNT_INIT;
          if (MEM_LATENCY == 1) begin
            bus.if_stop <= (owner == OWN_IF);
            bus.dc_stop <= (owner == OWN_DC);
            state       <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            bus.if_stop <= (owner == OWN_IF);
            bus.dc_stop <= (owner == OWN_DC);
            state       <= RESP;
          end
        end
        RESP: begin
          bus.if_stop <= 1'b0;
          bus.dc_stop <= 1'b0;
          if (!we_q && owner == OWN_IF) if_rdata_q <= bus.mem_rdata;
          if (!we_q && owner == OWN_DC) dc_rdata_q <= bus.mem_rdata;
          lock     <= (owner == OWN_DC) & second_q;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
